// File: rtl/fetch_queue_pkg.sv
// Shared RISC-V constants used by the fetch queue and the ID hazard/flush logic.
package fetch_queue_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch presents words, decode drains the queue head.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = fetch_queue_pkg::XLEN
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] PC_IF;
   logic [XLEN-1:0] INSTRUCTION_IF;
   logic            PCSrc;
   logic            PC_write;
   logic            ID_ready;
   logic            ID_valid;
   logic [XLEN-1:0] PC_ID;
   logic [XLEN-1:0] INSTRUCTION_ID;
   logic [CW-1:0]   count;

   modport master (
      output PC_IF, INSTRUCTION_IF, PCSrc, ID_ready,
      input  PC_write, ID_valid, PC_ID, INSTRUCTION_ID, count
   );

   modport slave (
      input  PC_IF, INSTRUCTION_IF, PCSrc, ID_ready,
      output PC_write, ID_valid, PC_ID, INSTRUCTION_ID, count
   );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue between IF and ID with first-word fall-through head and flush on redirect.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,  // power of two, at least 2
   parameter int unsigned XLEN  = fetch_queue_pkg::XLEN
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave fq
);

   import fetch_queue_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Full/empty come from registered state only, so PC_write never depends on ID_ready or PCSrc.
   always_comb begin
      full  = (count_q == CW'(DEPTH));
      empty = (count_q == '0);
      push  = !full && !fq.PCSrc;
      pop   = !empty && fq.ID_ready && !fq.PCSrc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (fq.PCSrc) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // Storage is deliberately unreset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fq.PC_IF;
         instr_mem[wr_ptr_q] <= fq.INSTRUCTION_IF;
      end
   end

   always_comb begin
      fq.PC_write       = !full;
      fq.ID_valid       = !empty;
      fq.PC_ID          = empty ? '0 : pc_mem[rd_ptr_q];
      fq.INSTRUCTION_ID = empty ? XLEN'(NOP) : instr_mem[rd_ptr_q];
      fq.count          = count_q;
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, async reset case, random vs queue model.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned XLEN  = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      bit          pcsrc;
      bit          ready;
      logic [31:0] pc;
      int unsigned cnt;
      bit          valid;
      bit          pcw;
      logic [31:0] pc_id;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   ent_t mq[$];
   vec_t vecs[$];

   fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ins_of(input logic [31:0] pc);
      return 32'h0010_0093 + pc;
   endfunction

   function automatic vec_t mk(input bit pcsrc, input bit ready, input logic [31:0] pc,
                               input int unsigned cnt, input bit valid, input bit pcw,
                               input logic [31:0] pc_id);
      vec_t v;
      v.pcsrc = pcsrc;
      v.ready = ready;
      v.pc    = pc;
      v.cnt   = cnt;
      v.valid = valid;
      v.pcw   = pcw;
      v.pc_id = pc_id;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the reference queue, then sample just after the edge.
   task automatic apply(input bit pcsrc, input bit ready, input logic [31:0] pc,
                        input logic [31:0] ins);
      bit do_pop;
      bit do_push;
      ent_t e;
      fq.PCSrc          = pcsrc;
      fq.ID_ready       = ready;
      fq.PC_IF          = pc;
      fq.INSTRUCTION_IF = ins;
      do_pop  = (mq.size() > 0) && ready && !pcsrc;
      do_push = (mq.size() < DEPTH) && !pcsrc;
      if (pcsrc) begin
         mq.delete();
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.pc  = pc;
            e.ins = ins;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] exp_pc;
      logic [31:0] exp_ins;
      exp_pc  = (mq.size() > 0) ? mq[0].pc : 32'h0;
      exp_ins = (mq.size() > 0) ? mq[0].ins : NOP;
      chk({tag, ".count"}, 32'(fq.count), 32'(mq.size()));
      chk({tag, ".ID_valid"}, 32'(fq.ID_valid), 32'(mq.size() > 0));
      chk({tag, ".PC_write"}, 32'(fq.PC_write), 32'(mq.size() < DEPTH));
      chk({tag, ".PC_ID"}, fq.PC_ID, exp_pc);
      chk({tag, ".INSTRUCTION_ID"}, fq.INSTRUCTION_ID, exp_ins);
   endtask

   initial begin
      int unsigned bias;
      bit          r_pcsrc;
      bit          r_ready;
      logic [31:0] r_pc;
      n_checks          = 0;
      n_errors          = 0;
      reset             = 1'b1;
      fq.PCSrc          = 1'b0;
      fq.ID_ready       = 1'b0;
      fq.PC_IF          = '0;
      fq.INSTRUCTION_IF = '0;

      // Reset state
      #12;
      chk("reset.count", 32'(fq.count), 32'd0);
      chk("reset.ID_valid", 32'(fq.ID_valid), 32'd0);
      chk("reset.PC_write", 32'(fq.PC_write), 32'd1);
      chk("reset.PC_ID", fq.PC_ID, 32'h0);
      chk("reset.INSTRUCTION_ID", fq.INSTRUCTION_ID, NOP);
      @(posedge clk);
      #1;
      reset = 1'b0;

      //           pcsrc rdy pc        cnt vld pcw pc_id
      vecs.push_back(mk(0, 1, 32'h000, 1, 1, 1, 32'h000));  // one-cycle fall-through
      vecs.push_back(mk(0, 1, 32'h004, 1, 1, 1, 32'h004));
      vecs.push_back(mk(0, 1, 32'h008, 1, 1, 1, 32'h008));
      vecs.push_back(mk(1, 1, 32'h099, 0, 0, 1, 32'h000));  // flush to empty
      vecs.push_back(mk(0, 0, 32'h000, 1, 1, 1, 32'h000));  // fill with decode stalled
      vecs.push_back(mk(0, 0, 32'h004, 2, 1, 1, 32'h000));
      vecs.push_back(mk(0, 0, 32'h008, 3, 1, 1, 32'h000));
      vecs.push_back(mk(0, 0, 32'h00C, 4, 1, 0, 32'h000));
      vecs.push_back(mk(0, 0, 32'h010, 4, 1, 0, 32'h000));  // full: 0x10 refused
      vecs.push_back(mk(0, 0, 32'h010, 4, 1, 0, 32'h000));
      vecs.push_back(mk(0, 1, 32'h010, 3, 1, 1, 32'h004));  // pop from full
      vecs.push_back(mk(0, 0, 32'h010, 4, 1, 0, 32'h004));  // 0x10 into wrapped slot
      vecs.push_back(mk(0, 1, 32'h014, 3, 1, 1, 32'h008));
      vecs.push_back(mk(0, 1, 32'h014, 3, 1, 1, 32'h00C));  // push+pop keeps count
      vecs.push_back(mk(0, 1, 32'h018, 3, 1, 1, 32'h010));
      vecs.push_back(mk(1, 1, 32'h01C, 0, 0, 1, 32'h000));  // redirect at count 3
      vecs.push_back(mk(0, 1, 32'h200, 1, 1, 1, 32'h200));  // branch target
      vecs.push_back(mk(0, 1, 32'h204, 1, 1, 1, 32'h204));

      foreach (vecs[i]) begin
         apply(vecs[i].pcsrc, vecs[i].ready, vecs[i].pc, ins_of(vecs[i].pc));
         chk($sformatf("vec%0d.count", i), 32'(fq.count), 32'(vecs[i].cnt));
         chk($sformatf("vec%0d.ID_valid", i), 32'(fq.ID_valid), 32'(vecs[i].valid));
         chk($sformatf("vec%0d.PC_write", i), 32'(fq.PC_write), 32'(vecs[i].pcw));
         chk($sformatf("vec%0d.PC_ID", i), fq.PC_ID, vecs[i].pc_id);
         chk($sformatf("vec%0d.INSTRUCTION_ID", i), fq.INSTRUCTION_ID,
             vecs[i].valid ? ins_of(vecs[i].pc_id) : NOP);
      end

      // Asynchronous reset mid-cycle with two entries held
      apply(1'b0, 1'b0, 32'h300, ins_of(32'h300));
      chk("pre_areset.count", 32'(fq.count), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      mq.delete();
      chk("areset.count", 32'(fq.count), 32'd0);
      chk("areset.ID_valid", 32'(fq.ID_valid), 32'd0);
      chk("areset.PC_write", 32'(fq.PC_write), 32'd1);
      chk("areset.PC_ID", fq.PC_ID, 32'h0);
      chk("areset.INSTRUCTION_ID", fq.INSTRUCTION_ID, NOP);
      @(negedge clk);
      reset = 1'b0;
      apply(1'b0, 1'b0, 32'h400, ins_of(32'h400));  // first edge after release pushes
      chk("post_reset.count", 32'(fq.count), 32'd1);
      chk("post_reset.PC_ID", fq.PC_ID, 32'h400);
      check_model("post_reset");

      // Random push/pop/flush against the reference queue
      bias = 50;
      for (int c = 0; c < 10000; c++) begin
         if (c % 200 == 0) bias = $urandom_range(10, 90);
         r_pcsrc = ($urandom_range(0, 99) < 4);
         r_ready = ($urandom_range(0, 99) < bias);
         r_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         apply(r_pcsrc, r_ready, r_pc, $urandom);
         check_model($sformatf("rand%0d", c));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
